// File: rtl/i2s_rx16_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg : shared definitions for the i2s_rx16 slave receiver.
//   state_t     - receiver FSM states (IDLE / SHIFT / PAD)
//   CH_LEFT     - channel tag for LCRK = 0
//   CH_RIGHT    - channel tag for LCRK = 1
//   DEF_DATA_W  - default audio word width
// -----------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/i2s_rx16_if.sv
// -----------------------------------------------------------------------------
// i2s_rx16_if : parallel word output bus of the I2S receiver.
//   data_out    - received word (master -> slave)
//   data_right  - channel of data_out, 1 = right (master -> slave)
//   data_valid  - data_out/data_right hold a word (master -> slave)
//   data_ready  - consumer takes the word on valid & ready (slave -> master)
//   overrun     - sticky: an unaccepted word was overwritten (master -> slave)
//   overrun_clr - synchronous clear of overrun (slave -> master)
// -----------------------------------------------------------------------------
interface i2s_rx16_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] data_out;
  logic              data_right;
  logic              data_valid;
  logic              data_ready;
  logic              overrun;
  logic              overrun_clr;

  modport master (
    output data_out,
    output data_right,
    output data_valid,
    output overrun,
    input  data_ready,
    input  overrun_clr
  );

  modport slave (
    input  data_out,
    input  data_right,
    input  data_valid,
    input  overrun,
    output data_ready,
    output overrun_clr
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// -----------------------------------------------------------------------------
// i2s_sync_edge : multi-flop synchronizer for one asynchronous input, with an
// optional registered rising-edge strobe.
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   i_d    - asynchronous input
//   o_q    - synchronized level
//   o_rise - one-cycle strobe after a 0->1 transition of o_q (0 if EDGE_EN=0)
// -----------------------------------------------------------------------------
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;
      logic r_rise;

      // The strobe is registered so that downstream logic sees it a fixed
      // SYNC_STAGES+1 edges after the input was first sampled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prev <= 1'b0;
          r_rise <= 1'b0;
        end else begin
          r_prev <= o_q;
          r_rise <= o_q & ~r_prev;
        end
      end

      assign o_rise = r_rise;
    end else begin : g_level
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_rx16.sv
// -----------------------------------------------------------------------------
// i2s_rx16 : slave-mode I2S receiver, one parallel word per half-frame.
//   CLK       - system clock (at least 6x BSCK)
//   RST       - asynchronous active-high reset
//   BSCK      - serial bit clock (async)
//   LCRK      - word select (async), 0 = left, 1 = right
//   RXD       - serial data (async), changes on BSCK falling edge
//   bus       - i2s_rx16_if.master: data_out/data_right/data_valid/overrun out,
//               data_ready/overrun_clr in
//   frame_err - only with I2S_RX_FRAME_ERR_EN defined: one-CLK pulse on a
//               short half-frame or bit-counter saturation
// Build option: I2S_RX_FRAME_ERR_EN adds frame_err.
// -----------------------------------------------------------------------------
module i2s_rx16
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BSCK,
  input  logic       LCRK,
  input  logic       RXD,
  i2s_rx16_if.master bus
`ifdef I2S_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Synchronized inputs
  logic w_bs_rise;
  logic w_bsck_lvl_unused;
  logic w_lcrk_s;
  logic w_lcrk_rise_unused;
  logic w_rxd_s;
  logic w_rxd_rise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bsck (
    .clk    (CLK),
    .rst    (RST),
    .i_d    (BSCK),
    .o_q    (w_bsck_lvl_unused),
    .o_rise (w_bs_rise)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lcrk (
    .clk    (CLK),
    .rst    (RST),
    .i_d    (LCRK),
    .o_q    (w_lcrk_s),
    .o_rise (w_lcrk_rise_unused)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_rxd (
    .clk    (CLK),
    .rst    (RST),
    .i_d    (RXD),
    .o_q    (w_rxd_s),
    .o_rise (w_rxd_rise_unused)
  );

  // LCRK history. r_lr_seen keeps the very first sample after reset from
  // being taken as a transition, so a partial half-frame is never captured.
  logic r_lr_prev;
  logic r_lr_seen;
  logic w_lr_edge;

  assign w_lr_edge = w_bs_rise & r_lr_seen & (w_lcrk_s != r_lr_prev);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lr_prev <= 1'b0;
      r_lr_seen <= 1'b0;
    end else if (w_bs_rise) begin
      r_lr_prev <= w_lcrk_s;
      r_lr_seen <= 1'b1;
    end
  end

  // FSM and serial datapath. The shift register holds DATA_W-1 bits: the last
  // bit of a word goes straight into the output register with the others.
  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-2:0] r_shift;
  logic [DATA_W-2:0] w_shift_next;
  logic [DATA_W-1:0] w_shift_in;
  logic              r_chan;
  logic              w_chan_next;
  logic              w_word_done;
`ifdef I2S_RX_FRAME_ERR_EN
  logic              w_short;
  logic              w_sat;
`endif

  assign w_shift_in = {r_shift, w_rxd_s};
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_chan  <= CH_LEFT;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
      r_chan  <= w_chan_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_chan_next  = r_chan;
    w_word_done  = 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
    w_short      = 1'b0;
    w_sat        = 1'b0;
`endif
    if (w_bs_rise) begin
      if (w_lr_edge) begin
        // This rise is the one-bit delay slot of the new half-frame; any
        // partial word still in SHIFT is dropped.
`ifdef I2S_RX_FRAME_ERR_EN
        w_short      = (r_state == SHIFT);
`endif
        w_state_next = SHIFT;
        w_cnt_next   = '0;
        w_shift_next = '0;
        w_chan_next  = w_lcrk_s ? CH_RIGHT : CH_LEFT;
      end else begin
        case (r_state)
          IDLE: begin
            w_state_next = IDLE;
          end
          SHIFT: begin
            w_shift_next = w_shift_in[DATA_W-2:0];
            w_cnt_next   = w_cnt_inc;
            if (w_cnt_inc == CNT_FULL) begin
              w_word_done  = 1'b1;
              w_state_next = PAD;
            end
          end
          PAD: begin
            if (r_cnt != CNT_MAX) begin
              w_cnt_next = w_cnt_inc;
`ifdef I2S_RX_FRAME_ERR_EN
              if (w_cnt_inc == CNT_MAX) begin
                w_sat        = 1'b1;
                w_state_next = IDLE;
              end
`endif
            end
          end
          default: begin
            w_state_next = IDLE;
          end
        endcase
      end
    end
  end

  // Output register and handshake
  logic [DATA_W-1:0] r_data;
  logic              r_right;
  logic              r_valid;
  logic              r_overrun;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data    <= '0;
      r_right   <= CH_LEFT;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_word_done) begin
        r_data  <= w_shift_in;
        r_right <= r_chan;
        r_valid <= 1'b1;
      end else if (r_valid && bus.data_ready) begin
        r_valid <= 1'b0;
      end
      // Setting wins over a simultaneous clear.
      if (w_word_done && r_valid && !bus.data_ready) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_right = r_right;
  assign bus.data_valid = r_valid;
  assign bus.overrun    = r_overrun;

`ifdef I2S_RX_FRAME_ERR_EN
  logic r_frame_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_short | w_sat;
    end
  end

  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_i2s_rx16.sv
`timescale 1ns/1ps
module tb_i2s_rx16;
  import i2s_pkg::*;

  localparam int DW     = 16;
  localparam int HALF   = 42;
  localparam int H_NONE = 0;
  localparam int H_LAT  = 1;
  localparam int H_COLL = 2;
  localparam int H_REL  = 3;
  localparam int H_RST  = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          right;
  } word_t;

  logic CLK  = 1'b0;
  logic RST  = 1'b1;
  logic BSCK = 1'b0;
  logic LCRK = 1'b0;
  logic RXD  = 1'b0;

  i2s_rx16_if #(.DATA_W(DW)) bus ();

`ifdef I2S_RX_FRAME_ERR_EN
  logic frame_err;
`endif

  i2s_rx16 #(.DATA_W(DW), .CNT_W(6), .SYNC_STAGES(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .BSCK (BSCK),
    .LCRK (LCRK),
    .RXD  (RXD),
    .bus  (bus)
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #HALF CLK = ~CLK;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t exp_q[$];
  bit    exp_overrun = 1'b0;
  int    ferr_cnt = 0;
  int    ferr_exp = 0;
  bit    model_lr_known = 1'b0;
  bit    model_prev_lr = 1'b0;
  bit    model_prev_entered = 1'b0;
  bit    model_prev_short = 1'b0;
  bit    rnd_ready = 1'b0;
  bit    stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word must be the oldest outstanding expected word.
  always @(negedge CLK) begin
    if (!RST && bus.data_valid && bus.data_ready) begin
      word_t e;
      $display("[TB] accept data=%h right=%0d", bus.data_out, bus.data_right);
      check("word_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_out", bus.data_out, e.data);
        check("data_right", bus.data_right, e.right);
      end
    end
`ifdef I2S_RX_FRAME_ERR_EN
    if (!RST && frame_err) ferr_cnt++;
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rnd_ready) bus.data_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One BSCK period = 8 CLK; LCRK and RXD change with the falling edge.
  task automatic send_bit(input bit lr, input bit d);
    tick();
    BSCK = 1'b0;
    LCRK = lr;
    RXD  = d;
    repeat (3) tick();
    tick();
    BSCK = 1'b1;
    repeat (3) tick();
  endtask

  // Half-frame: slot 0 is the delay slot, slots 1..DW carry the word MSB
  // first, further slots are padding. The model decides at word level whether
  // the half-frame yields an output.
  task automatic send_half(input bit lr, input logic [DW-1:0] w, input int nbits,
                           input int hook, input int hook_at);
    bit    entered;
    bit    was_reset;
    bit    d;
    word_t e;
    was_reset = 1'b0;
    entered   = model_lr_known && (lr != model_prev_lr);
    if (entered && model_prev_entered && model_prev_short) ferr_exp++;
    if (entered && nbits >= DW + 1) begin
      e.data  = w;
      e.right = lr;
      if (stall && hook != H_COLL && exp_q.size() != 0) begin
        exp_q[exp_q.size()-1] = e;
        exp_overrun = 1'b1;
      end else begin
        exp_q.push_back(e);
      end
    end
    $display("[TB] half-frame lr=%0d word=%h bits=%0d hook=%0d", lr, w, nbits, hook);
    for (int b = 0; b < nbits; b++) begin
      if (hook == H_REL && b == hook_at) RST = 1'b0;
      if (hook == H_RST && b == hook_at) begin
        tick();
        RST = 1'b1;
        #1;
        check("rst_mid_data", bus.data_out, '0);
        check("rst_mid_valid", bus.data_valid, 1'b0);
        check("rst_mid_right", bus.data_right, 1'b0);
        check("rst_mid_overrun", bus.overrun, 1'b0);
        exp_q.delete();
        exp_overrun = 1'b0;
        was_reset = 1'b1;
        tick();
        RST = 1'b0;
      end
      if (b >= 1 && b <= DW) d = w[DW-b];
      else d = 1'($urandom_range(0, 1));
      send_bit(lr, d);
      if (b == DW && hook == H_LAT) begin
        check("lat_early_valid", bus.data_valid, 1'b0);
        tick();
        check("lat_valid", bus.data_valid, 1'b1);
        check("lat_data", bus.data_out, w);
      end
      if (b == DW && hook == H_COLL) begin
        bus.data_ready = 1'b1;
        stall = 1'b0;
        tick();
        check("coll_valid", bus.data_valid, 1'b1);
        check("coll_data", bus.data_out, w);
        check("coll_overrun", bus.overrun, 1'b0);
      end
    end
    model_lr_known     = 1'b1;
    model_prev_lr      = lr;
    model_prev_entered = entered && !was_reset;
    model_prev_short   = (nbits < DW + 1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    bit            lr;
    int            nb;

    bus.data_ready  = 1'b0;
    bus.overrun_clr = 1'b0;
    RST = 1'b1;
    idle(3);
    check("reset_data", bus.data_out, '0);
    check("reset_valid", bus.data_valid, 1'b0);
    check("reset_right", bus.data_right, 1'b0);
    check("reset_overrun", bus.overrun, 1'b0);

    // Startup mid-frame: reset released 5 BSCK into a left half-frame.
    bus.data_ready = 1'b1;
    send_half(1'b0, 16'($urandom), 24, H_REL, 5);
    send_half(1'b1, 16'h5AC3, 24, H_NONE, 0);
    idle(8);
    check("startup_drain", exp_q.size(), 0);

    // Nominal left/right words with completion latency.
    send_half(1'b0, 16'hA55A, 24, H_LAT, 0);
    send_half(1'b1, 16'h1234, 24, H_LAT, 0);
    idle(8);
    check("nominal_drain", exp_q.size(), 0);
    check("nominal_overrun", bus.overrun, exp_overrun);

    // Backpressure: two words without acceptance.
    stall = 1'b1;
    bus.data_ready = 1'b0;
    send_half(1'b0, 16'h0001, 24, H_NONE, 0);
    send_half(1'b1, 16'h0002, 24, H_NONE, 0);
    idle(8);
    check("bp_data", bus.data_out, 16'h0002);
    check("bp_right", bus.data_right, 1'b1);
    check("bp_valid", bus.data_valid, 1'b1);
    check("bp_overrun", bus.overrun, 1'b1);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    exp_overrun = 1'b0;
    check("bp_overrun_clr", bus.overrun, exp_overrun);
    check("bp_valid_hold", bus.data_valid, 1'b1);
    stall = 1'b0;
    bus.data_ready = 1'b1;
    idle(4);
    check("bp_drain", exp_q.size(), 0);

    // Accept/complete collision.
    stall = 1'b1;
    bus.data_ready = 1'b0;
    send_half(1'b0, 16'($urandom), 24, H_NONE, 0);
    send_half(1'b1, 16'($urandom), 24, H_COLL, 0);
    idle(8);
    check("coll_drain", exp_q.size(), 0);
    check("coll_overrun_end", bus.overrun, exp_overrun);

    // Short half-frame: 10 data bits, then a full word.
    send_half(1'b0, 16'($urandom), 11, H_NONE, 0);
    send_half(1'b1, 16'hFFFF, 24, H_NONE, 0);
    send_half(1'b0, 16'($urandom), 24, H_NONE, 0);
    idle(8);
    check("short_drain", exp_q.size(), 0);
`ifdef I2S_RX_FRAME_ERR_EN
    check("short_frame_err", ferr_cnt, ferr_exp);
`endif

    // Reset mid-word with a pending word held by backpressure.
    stall = 1'b1;
    bus.data_ready = 1'b0;
    w = 16'($urandom);
    send_half(1'b1, w, 24, H_NONE, 0);
    idle(4);
    check("pend_data", bus.data_out, w);
    check("pend_valid", bus.data_valid, 1'b1);
    send_half(1'b0, 16'hC3C3, 24, H_RST, 9);
    stall = 1'b0;
    bus.data_ready = 1'b1;
    send_half(1'b1, 16'($urandom), 24, H_NONE, 0);
    idle(8);
    check("rst_drain", exp_q.size(), 0);

    // Randomized half-frames with random consumer readiness.
    rnd_ready = 1'b1;
    lr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) nb = $urandom_range(8, 16);
      else nb = $urandom_range(17, 32);
      send_half(lr, 16'($urandom), nb, H_NONE, 0);
      lr = ~lr;
    end
    rnd_ready = 1'b0;
    bus.data_ready = 1'b1;
    idle(10);
    check("rand_drain", exp_q.size(), 0);
    check("rand_overrun", bus.overrun, exp_overrun);
`ifdef I2S_RX_FRAME_ERR_EN
    check("rand_frame_err", ferr_cnt, ferr_exp);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
